// File: rtl/nibble_frame_qualifier_pkg.sv
// Shared types and constants for the nibble frame qualifier: FSM encoding,
// qualifier bit positions and a helper that packs the individual check results.
package nibq_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      DATA    = 3'd1,
      PARITY  = 3'd2,
      STOP    = 3'd3,
      PRESENT = 3'd4
   } nibq_state_e;

   localparam int QUAL_W  = 6;

   localparam int Q_OK    = 0;
   localparam int Q_NORST = 1;
   localparam int Q_NOGAP = 2;
   localparam int Q_PAR   = 3;
   localparam int Q_STOP  = 4;
   localparam int Q_NOOVR = 5;

   function automatic logic [QUAL_W-1:0] pack_qual(
      input logic ok,
      input logic norst,
      input logic nogap,
      input logic par,
      input logic stop,
      input logic noovr
   );
      logic [QUAL_W-1:0] q;
      q          = '0;
      q[Q_OK]    = ok;
      q[Q_NORST] = norst;
      q[Q_NOGAP] = nogap;
      q[Q_PAR]   = par;
      q[Q_STOP]  = stop;
      q[Q_NOOVR] = noovr;
      return q;
   endfunction

endpackage

// File: rtl/nibble_frame_qualifier_if.sv
// Serial-in / word-out bundle of the nibble frame qualifier.
// The slave modport is the qualifier itself; the master side drives the serial bits and consumes words.
interface nibble_frame_qualifier_if
   import nibq_pkg::*;
#(
   parameter int DATA_W = 4
);

   logic                frame_start;
   logic                ser_valid;
   logic                ser_in;
   logic                ok_in;
   logic                out_ready;
   logic                out_valid;
   logic [0:DATA_W-1]   data_out;
   logic [QUAL_W-1:0]   qual_out;

   modport slave (
      input  frame_start,
      input  ser_valid,
      input  ser_in,
      input  ok_in,
      input  out_ready,
      output out_valid,
      output data_out,
      output qual_out
   );

   modport master (
      output frame_start,
      output ser_valid,
      output ser_in,
      output ok_in,
      output out_ready,
      input  out_valid,
      input  data_out,
      input  qual_out
   );

endinterface

// File: rtl/nibble_frame_qualifier_gap_timer.sv
// Counts consecutive idle cycles inside a frame; pulses timeout on the idle cycle
// that exceeds MAX_GAP. The count saturates at MAX_GAP+1 and never wraps.
module gap_timer #(
   parameter int MAX_GAP = 7
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic tick,
   output logic timeout
);

   localparam int            CW  = $clog2(MAX_GAP + 2);
   localparam logic [CW-1:0] SAT = CW'(MAX_GAP + 1);
   localparam logic [CW-1:0] LIM = CW'(MAX_GAP);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (tick && (count_q != SAT)) begin
         count_d = count_q + CW'(1);
      end
   end

   // count_q already holds MAX_GAP idles, so this tick is the one that overflows the budget
   assign timeout = tick && !clear && (count_q >= LIM);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/nibble_frame_qualifier.sv
// Assembles start/data/parity/stop serial frames into a nibble plus a 6-bit
// qualifier vector (1 = check passed) for the downstream error-substitution stage.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | waiting for frame_start&ser_valid (that cycle carries bit 0)
//   DATA    | collecting data bits 1..DATA_W-1
//   PARITY  | waiting for the parity bit
//   STOP    | waiting for the stop bit
//   PRESENT | word on the outputs, held until out_valid&out_ready
module nibble_frame_qualifier
   import nibq_pkg::*;
#(
   parameter int DATA_W  = 4,
   parameter int MAX_GAP = 7
) (
   input  logic clk,
   input  logic rst,
   nibble_frame_qualifier_if.slave bus
);

   localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   nibq_state_e         state_q,     state_d;
   logic [CNT_W-1:0]    bit_cnt_q,   bit_cnt_d;
   logic [0:DATA_W-1]   data_q,      data_d;
   logic                par_acc_q,   par_acc_d;
   logic                par_bit_q,   par_bit_d;
   logic                ok_acc_q,    ok_acc_d;
   logic                restart_q,   restart_d;
   logic                ovr_q,       ovr_d;
   logic [QUAL_W-1:0]   qual_q,      qual_d;

   logic start_v;
   logic in_frame;
   logic present;
   logic handshake;
   logic load_first;
   logic gap_clear;
   logic gap_tick;
   logic gap_timeout;

   assign start_v   = bus.frame_start & bus.ser_valid;
   assign in_frame  = (state_q == DATA) || (state_q == PARITY) || (state_q == STOP);
   assign present   = (state_q == PRESENT);
   assign handshake = present & bus.out_ready;
   assign gap_clear = !in_frame || bus.ser_valid;
   assign gap_tick  = in_frame && !bus.ser_valid;

   gap_timer #(
      .MAX_GAP (MAX_GAP)
   ) u_gap_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (gap_clear),
      .tick    (gap_tick),
      .timeout (gap_timeout)
   );

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      data_d     = data_q;
      par_acc_d  = par_acc_q;
      par_bit_d  = par_bit_q;
      ok_acc_d   = ok_acc_q;
      restart_d  = restart_q;
      ovr_d      = ovr_q;
      qual_d     = qual_q;
      load_first = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_v) begin
               load_first = 1'b1;
               restart_d  = 1'b0;
            end
         end

         DATA, PARITY, STOP: begin
            if (start_v) begin
               load_first = 1'b1;
               restart_d  = 1'b1;
            end else if (bus.ser_valid) begin
               ok_acc_d = ok_acc_q & bus.ok_in;
               case (state_q)
                  DATA: begin
                     data_d[bit_cnt_q] = bus.ser_in;
                     par_acc_d         = par_acc_q ^ bus.ser_in;
                     if (bit_cnt_q == LAST_BIT) begin
                        state_d = PARITY;
                     end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                     end
                  end
                  PARITY: begin
                     par_bit_d = bus.ser_in;
                     state_d   = STOP;
                  end
                  default: begin
                     qual_d  = pack_qual(ok_acc_q & bus.ok_in, !restart_q, 1'b1,
                                         par_bit_q == par_acc_q, bus.ser_in, !ovr_q);
                     state_d = PRESENT;
                  end
               endcase
            end else if (gap_timeout) begin
               // bits never received stay 0 from the frame-entry clear
               qual_d  = pack_qual(ok_acc_q, !restart_q, 1'b0, 1'b0, 1'b0, !ovr_q);
               state_d = PRESENT;
            end
         end

         PRESENT: begin
            if (handshake) begin
               // only the word that reported the overrun retires the sticky flag
               if (!qual_q[Q_NOOVR]) begin
                  ovr_d = 1'b0;
               end
               if (start_v) begin
                  load_first = 1'b1;
                  restart_d  = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end else if (start_v) begin
               ovr_d = 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      if (load_first) begin
         state_d   = DATA;
         bit_cnt_d = CNT_W'(1);
         data_d    = '0;
         data_d[0] = bus.ser_in;
         par_acc_d = bus.ser_in;
         par_bit_d = 1'b0;
         ok_acc_d  = bus.ok_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         data_q    <= '0;
         par_acc_q <= 1'b0;
         par_bit_q <= 1'b0;
         ok_acc_q  <= 1'b0;
         restart_q <= 1'b0;
         ovr_q     <= 1'b0;
         qual_q    <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         data_q    <= data_d;
         par_acc_q <= par_acc_d;
         par_bit_q <= par_bit_d;
         ok_acc_q  <= ok_acc_d;
         restart_q <= restart_d;
         ovr_q     <= ovr_d;
         qual_q    <= qual_d;
      end
   end

   always_comb begin
      bus.out_valid = present;
      bus.data_out  = present ? data_q : '0;
      bus.qual_out  = present ? qual_q : '0;
   end

endmodule
